// File: rtl/sign_apply_serial_pkg.sv
// Shared types for the bit-serial sign restoration block.
// FSM state encoding used by the top and by anything probing it.
package sign_apply_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sign_apply_serial_half.sv
// Single half-adder cell reused for every serial bit.
// Sum and carry of two one-bit operands.
module adder_1bit_half (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  // Plain half-adder equations.
  always_comb begin
    sum  = a ^ b;
    cout = a & b;
  end

endmodule

// File: rtl/sign_apply_serial.sv
// Bit-serial sign restoration: result = sign ? -mag : mag.
// One bit per cycle, LSB first, through one half-adder cell.
module sign_apply_serial
  import sign_apply_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             cell_a;
  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] res_full;

  // Current bit: conditionally inverted magnitude plus the running carry.
  assign cell_a   = mag_q[0] ^ sign_q;
  assign res_full = {cell_sum, res_q};

  adder_1bit_half u_cell (
    .a    (cell_a),
    .b    (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    res_d     = res_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mag_d   = in_mag;
          sign_d  = in_sign;
          carry_d = in_sign;
          cnt_d   = '0;
          ovf_d   = in_mag[WIDTH-1] &&
                    (!in_sign || (|in_mag[WIDTH-2:0]));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mag_d   = mag_q >> 1;
        carry_d = cell_cout;
        res_d   = res_full[WIDTH-1:1];
        if (cnt_q == LAST) begin
          data_d  = res_full;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      res_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      res_q   <= res_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data = data_q;
  assign out_ovf  = ovf_q;

endmodule
